// File: rtl/sccb_target.sv
// sccb_target -- SCCB/I2C target (responder) working from oversampled SCL/SDA.
//
// Receives a device-ID byte, one or two sub-address bytes and any number of
// write data bytes. Register accesses appear on a strobe bus. SDA is driven
// open-drain for ACK and for read data.
//
// Ports
//   clk        system clock, at least 16x the SCL rate
//   rst        asynchronous reset, active-high
//   scl_in     SCL pin level (asynchronous)
//   sda_in     SDA pin level (asynchronous)
//   sda_oe     1 = pull SDA low, 0 = release
//   reg_addr   current register address
//   reg_wdata  write data, valid while reg_we = 1
//   reg_we     one-clock write strobe
//   reg_re     one-clock read strobe; reg_rdata is sampled on the clock after
//   reg_rdata  read data
//   busy       high from START to STOP
module sccb_target #(
  parameter logic [6:0] DEV_ADDR   = 7'h36,
  parameter int         ADDR_BYTES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [7:0]  reg_rdata,
  output logic        busy
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_DEV, ST_ACK_DEV, ST_ADDR_HI, ST_ACK_AH, ST_ADDR_LO,
    ST_ACK_AL, ST_WDATA, ST_ACK_WD, ST_RDATA, ST_MACK, ST_IGNORE
  } state_t;

  // First address state after the device ID depends on the sub-address width.
  localparam state_t FIRST_ADDR = (ADDR_BYTES == 1) ? ST_ADDR_LO : ST_ADDR_HI;

  // Pin synchronisers plus one delay stage for edge detection.
  logic scl_s1_reg, scl_s2_reg, scl_d_reg;
  logic sda_s1_reg, sda_s2_reg, sda_d_reg;

  state_t      state_reg, state_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  rx_sr_reg, rx_sr_next;
  logic [7:0]  tx_sr_reg, tx_sr_next;
  logic        rw_reg, rw_next;
  logic        re_d_reg, re_d_next;
  logic        sda_oe_reg, sda_oe_next;
  logic        busy_reg, busy_next;
  logic [15:0] addr_reg, addr_next;
  logic [7:0]  wdata_reg, wdata_next;
  logic        we_reg, we_next;
  logic        re_reg, re_next;

  logic       scl_rise, scl_fall, start_det, stop_det, rx_done;
  logic [7:0] rx_byte;

  assign scl_rise  = scl_s2_reg & ~scl_d_reg;
  assign scl_fall  = ~scl_s2_reg & scl_d_reg;
  assign start_det = scl_s2_reg & scl_d_reg & sda_d_reg & ~sda_s2_reg;
  assign stop_det  = scl_s2_reg & scl_d_reg & ~sda_d_reg & sda_s2_reg;
  // Byte as it will look once the current SCL-rise bit is shifted in.
  assign rx_byte   = {rx_sr_reg[6:0], sda_s2_reg};
  assign rx_done   = scl_rise && (bit_cnt_reg == 4'd7);

  // Synchronisers reset to the idle-bus level so leaving reset never looks
  // like a START or STOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1_reg <= 1'b1;
      scl_s2_reg <= 1'b1;
      scl_d_reg  <= 1'b1;
      sda_s1_reg <= 1'b1;
      sda_s2_reg <= 1'b1;
      sda_d_reg  <= 1'b1;
    end else begin
      scl_s1_reg <= scl_in;
      scl_s2_reg <= scl_s1_reg;
      scl_d_reg  <= scl_s2_reg;
      sda_s1_reg <= sda_in;
      sda_s2_reg <= sda_s1_reg;
      sda_d_reg  <= sda_s2_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= 4'd0;
      rx_sr_reg   <= 8'h00;
      tx_sr_reg   <= 8'h00;
      rw_reg      <= 1'b0;
      re_d_reg    <= 1'b0;
      sda_oe_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      addr_reg    <= 16'h0000;
      wdata_reg   <= 8'h00;
      we_reg      <= 1'b0;
      re_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      rx_sr_reg   <= rx_sr_next;
      tx_sr_reg   <= tx_sr_next;
      rw_reg      <= rw_next;
      re_d_reg    <= re_d_next;
      sda_oe_reg  <= sda_oe_next;
      busy_reg    <= busy_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      we_reg      <= we_next;
      re_reg      <= re_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    rx_sr_next   = rx_sr_reg;
    tx_sr_next   = tx_sr_reg;
    rw_next      = rw_reg;
    re_d_next    = re_reg;
    sda_oe_next  = sda_oe_reg;
    busy_next    = busy_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    we_next      = 1'b0;
    re_next      = 1'b0;

    // Post-increment the address the clock after a write strobe.
    if (we_reg) addr_next = addr_reg + 16'd1;
    // Read data is captured one clock after the strobe; the next SCL fall
    // that needs it is many clocks later.
    if (re_d_reg) tx_sr_next = reg_rdata;

    if (start_det) begin
      state_next   = ST_DEV;
      bit_cnt_next = 4'd0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b1;
    end else if (stop_det) begin
      state_next  = ST_IDLE;
      sda_oe_next = 1'b0;
      busy_next   = 1'b0;
    end else begin
      case (state_reg)
        ST_DEV, ST_ADDR_HI, ST_ADDR_LO, ST_WDATA: begin
          if (scl_rise) begin
            rx_sr_next   = rx_byte;
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
          if (rx_done) begin
            bit_cnt_next = 4'd0;
            case (state_reg)
              ST_DEV: begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  rw_next    = rx_byte[0];
                  re_next    = rx_byte[0];
                  state_next = ST_ACK_DEV;
                end else begin
                  state_next = ST_IGNORE;
                end
              end
              ST_ADDR_HI: begin
                addr_next  = {rx_byte, addr_reg[7:0]};
                state_next = ST_ACK_AH;
              end
              ST_ADDR_LO: begin
                addr_next  = (ADDR_BYTES == 1) ? {8'h00, rx_byte}
                                               : {addr_reg[15:8], rx_byte};
                state_next = ST_ACK_AL;
              end
              default: begin
                wdata_next = rx_byte;
                we_next    = 1'b1;
                state_next = ST_ACK_WD;
              end
            endcase
          end
        end

        // ACK slot: first SCL fall pulls SDA low, second (end of the 9th
        // clock) releases it and moves on.
        ST_ACK_DEV, ST_ACK_AH, ST_ACK_AL, ST_ACK_WD: begin
          if (scl_fall) begin
            if (!sda_oe_reg) begin
              sda_oe_next = 1'b1;
            end else begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = 4'd0;
              case (state_reg)
                ST_ACK_DEV: begin
                  if (rw_reg) begin
                    // Release of the ACK is also the setup edge of the first
                    // read bit.
                    state_next   = ST_RDATA;
                    sda_oe_next  = ~tx_sr_reg[7];
                    tx_sr_next   = {tx_sr_reg[6:0], 1'b0};
                    bit_cnt_next = 4'd1;
                  end else begin
                    state_next = FIRST_ADDR;
                  end
                end
                ST_ACK_AH: state_next = ST_ADDR_LO;
                default:   state_next = ST_WDATA;
              endcase
            end
          end
        end

        ST_RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_reg == 4'd8) begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = 4'd0;
              state_next   = ST_MACK;
            end else begin
              sda_oe_next  = ~tx_sr_reg[7];
              tx_sr_next   = {tx_sr_reg[6:0], 1'b0};
              bit_cnt_next = bit_cnt_reg + 4'd1;
            end
          end
        end

        ST_MACK: begin
          if (scl_rise) begin
            if (!sda_s2_reg) begin
              addr_next    = addr_reg + 16'd1;
              re_next      = 1'b1;
              bit_cnt_next = 4'd0;
              state_next   = ST_RDATA;
            end else begin
              state_next = ST_IGNORE;
            end
          end
        end

        default: ;
      endcase
    end
  end

  assign sda_oe    = sda_oe_reg;
  assign reg_addr  = addr_reg;
  assign reg_wdata = wdata_reg;
  assign reg_we    = we_reg;
  assign reg_re    = re_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target -- directed bench for sccb_target acting as an SCCB master
// with a small register-file model behind the strobe bus.
module tb_sccb_target;

  localparam int Q = 10;  // clocks per SCL quarter-phase

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_drv = 1'b1;
  logic        sda_drv = 1'b1;
  logic        sda_pin;
  logic        sda_oe;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [7:0]  reg_rdata;
  logic        busy;

  always #5 clk = ~clk;

  // Open-drain bus: either side may pull low.
  assign sda_pin = sda_drv & ~sda_oe;
  // Register model: one known location, everything else a simple pattern.
  assign reg_rdata = (reg_addr == 16'h300A) ? 8'h56 : (reg_addr[7:0] ^ 8'hA5);

  sccb_target #(.DEV_ADDR(7'h36), .ADDR_BYTES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_drv),
    .sda_in    (sda_pin),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  // Strobe monitor, sampled on the inactive edge.
  logic [15:0] we_addr_q[$];
  logic [7:0]  we_data_q[$];
  logic [15:0] re_addr_q[$];
  int          oe_cnt = 0;

  always @(negedge clk) begin
    if (reg_we) begin
      we_addr_q.push_back(reg_addr);
      we_data_q.push_back(reg_wdata);
    end
    if (reg_re) re_addr_q.push_back(reg_addr);
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] q16(input logic [15:0] q[$], input int idx);
    return (idx < q.size()) ? q[idx] : 16'hxxxx;
  endfunction

  function automatic logic [7:0] q8(input logic [7:0] q[$], input int idx);
    return (idx < q.size()) ? q[idx] : 8'hxx;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic bus_start();
    sda_drv = 1'b1; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    sda_drv = 1'b0; wait_clk(Q);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    sda_drv = 1'b1; wait_clk(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b;    wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  // Sends a byte and reports whether the target held sda_oe in the 9th clock.
  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_drv = 1'b1; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q / 2);
    @(negedge clk);
    acked = sda_oe & ~sda_pin;
    wait_clk(Q / 2);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sda_drv = 1'b1; wait_clk(Q);
      scl_drv = 1'b1; wait_clk(Q / 2);
      @(negedge clk);
      d = {d[6:0], sda_pin};
      wait_clk(Q / 2);
      scl_drv = 1'b0; wait_clk(Q);
    end
    sda_drv = mack; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  typedef struct {
    logic [31:0] bytes;
    int          nbytes;
    int          exp_acks;
    int          exp_we;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wdata;
  } wvec_t;

  wvec_t vecs[5];

  initial begin
    logic        ack;
    logic [7:0]  d;
    logic [31:0] bytes;
    int          acks, we_base, re_base, oe_base;

    vecs[0] = '{32'h6C30_0842, 4, 4, 1, 16'h3008, 8'h42};
    vecs[1] = '{32'h6C12_34A5, 4, 4, 1, 16'h1234, 8'hA5};
    vecs[2] = '{32'h7830_0842, 4, 0, 0, 16'h0000, 8'h00};
    vecs[3] = '{32'h6C00_FF00, 4, 4, 1, 16'h00FF, 8'h00};
    vecs[4] = '{32'h6C30_0A00, 3, 3, 0, 16'h0000, 8'h00};

    // Reset state
    wait_clk(4);
    @(negedge clk);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    wait_clk(4);
    @(negedge clk);
    chk("rst_addr", reg_addr, 16'h0000);
    chk("rst_wdata", reg_wdata, 8'h00);
    chk("rst_we", reg_we, 0);
    chk("rst_re", reg_re, 0);

    // Table-driven write transactions
    for (int v = 0; v < 5; v++) begin
      we_base = we_addr_q.size();
      re_base = re_addr_q.size();
      oe_base = oe_cnt;
      acks    = 0;
      bytes   = vecs[v].bytes;
      bus_start();
      chk($sformatf("v%0d_busy_start", v), busy, 1);
      for (int k = 0; k < vecs[v].nbytes; k++) begin
        send_byte(bytes[31 - 8 * k -: 8], ack);
        if (ack) acks++;
      end
      bus_stop();
      @(negedge clk);
      $display("txn write v%0d: bytes=%08h acks=%0d we=%0d", v, bytes, acks,
               we_addr_q.size() - we_base);
      chk($sformatf("v%0d_acks", v), acks, vecs[v].exp_acks);
      chk($sformatf("v%0d_we_cnt", v), we_addr_q.size() - we_base, vecs[v].exp_we);
      chk($sformatf("v%0d_re_cnt", v), re_addr_q.size() - re_base, 0);
      chk($sformatf("v%0d_busy_stop", v), busy, 0);
      if (vecs[v].exp_we > 0) begin
        chk($sformatf("v%0d_we_addr", v), q16(we_addr_q, we_base), vecs[v].exp_addr);
        chk($sformatf("v%0d_we_data", v), q8(we_data_q, we_base), vecs[v].exp_wdata);
      end
      if (vecs[v].exp_acks == 0) chk($sformatf("v%0d_oe_never", v), oe_cnt - oe_base, 0);
    end
    chk("addr_after_setup", reg_addr, 16'h300A);

    // Single read with NACK
    re_base = re_addr_q.size();
    bus_start();
    send_byte(8'h6D, ack);
    chk("rd1_hdr_ack", ack, 1);
    recv_byte(1'b1, d);
    oe_base = oe_cnt;
    bus_stop();
    @(negedge clk);
    $display("txn read1: data=%02h re=%0d", d, re_addr_q.size() - re_base);
    chk("rd1_data", d, 8'h56);
    chk("rd1_re_cnt", re_addr_q.size() - re_base, 1);
    chk("rd1_re_addr", q16(re_addr_q, re_base), 16'h300A);
    chk("rd1_oe_after_nack", oe_cnt - oe_base, 0);
    chk("rd1_busy", busy, 0);

    // Two-byte read: ACK then NACK
    re_base = re_addr_q.size();
    bus_start();
    send_byte(8'h6D, ack);
    recv_byte(1'b0, d);
    chk("rd2_data0", d, 8'h56);
    recv_byte(1'b1, d);
    chk("rd2_data1", d, 8'hAE);
    bus_stop();
    @(negedge clk);
    $display("txn read2: last=%02h re=%0d", d, re_addr_q.size() - re_base);
    chk("rd2_re_cnt", re_addr_q.size() - re_base, 2);
    chk("rd2_re_addr1", q16(re_addr_q, re_base + 1), 16'h300B);

    // Burst write across the address wrap
    we_base = we_addr_q.size();
    bus_start();
    send_byte(8'h6C, ack);
    send_byte(8'hFF, ack);
    send_byte(8'hFF, ack);
    send_byte(8'h11, ack);
    send_byte(8'h22, ack);
    chk("burst_last_ack", ack, 1);
    bus_stop();
    @(negedge clk);
    $display("txn burst: we=%0d addr=%04h", we_addr_q.size() - we_base, reg_addr);
    chk("burst_we_cnt", we_addr_q.size() - we_base, 2);
    chk("burst_addr0", q16(we_addr_q, we_base), 16'hFFFF);
    chk("burst_data0", q8(we_data_q, we_base), 8'h11);
    chk("burst_addr1", q16(we_addr_q, we_base + 1), 16'h0000);
    chk("burst_data1", q8(we_data_q, we_base + 1), 8'h22);
    chk("burst_final_addr", reg_addr, 16'h0001);

    // Repeated START in the middle of a data byte
    we_base = we_addr_q.size();
    bus_start();
    send_byte(8'h6C, ack);
    send_byte(8'h30, ack);
    send_byte(8'h08, ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bus_start();
    send_byte(8'h6C, ack);
    chk("rs_hdr_ack", ack, 1);
    send_byte(8'h30, ack);
    send_byte(8'h09, ack);
    chk("rs_addr_ack", ack, 1);
    bus_stop();
    @(negedge clk);
    $display("txn rstart: we=%0d addr=%04h", we_addr_q.size() - we_base, reg_addr);
    chk("rs_we_cnt", we_addr_q.size() - we_base, 0);
    chk("rs_addr", reg_addr, 16'h3009);

    // STOP in the middle of a data byte
    bus_start();
    send_byte(8'h6C, ack);
    send_byte(8'h30, ack);
    send_byte(8'h09, ack);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    bus_stop();
    @(negedge clk);
    $display("txn midstop: we=%0d busy=%0b", we_addr_q.size() - we_base, busy);
    chk("ms_we_cnt", we_addr_q.size() - we_base, 0);
    chk("ms_busy", busy, 0);

    // Reset while the target is driving the header ACK
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(bytes_hdr(i));
    @(negedge clk);
    chk("ar_oe_before", sda_oe, 1);
    rst = 1'b1;
    #1;
    chk("ar_oe_async", sda_oe, 0);
    chk("ar_busy_async", busy, 0);
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    wait_clk(3);
    @(negedge clk);
    rst = 1'b0;
    wait_clk(Q);
    we_base = we_addr_q.size();
    acks = 0;
    bus_start();
    send_byte(8'h6C, ack); if (ack) acks++;
    send_byte(8'h40, ack); if (ack) acks++;
    send_byte(8'h00, ack); if (ack) acks++;
    send_byte(8'h77, ack); if (ack) acks++;
    bus_stop();
    @(negedge clk);
    $display("txn after_rst: acks=%0d we=%0d", acks, we_addr_q.size() - we_base);
    chk("ar_acks", acks, 4);
    chk("ar_we_addr", q16(we_addr_q, we_base), 16'h4000);
    chk("ar_we_data", q8(we_data_q, we_base), 8'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bits of the write header 0x6C, used where the byte is clocked bit by bit.
  function automatic logic bytes_hdr(input int i);
    logic [7:0] h;
    h = 8'h6C;
    return h[i];
  endfunction

endmodule
